mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage_pkg.sv | 41 ++++
 rtl/mem_access_stage_lane_align.sv | 49 ++++
 rtl/mem_access_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: RV64 load/store funct3 codes,
// FSM states and lane-offset helpers used by both the stage and its lane aligner.
package mem_access_stage_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    // funct3[1:0] encodes access size for both loads and stores; low bits below the size are dropped.
    function automatic logic [2:0] lane_offset(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b00:   return off;
            2'b01:   return {off[2:1], 1'b0};
            2'b10:   return {off[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
        return lane_offset(f3, off) == off;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational store lane shift/strobe generation and load
// byte-lane extraction with sign/zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_off,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_ld_word,
    output logic [XLEN-1:0] o_st_wdata,
    output logic [7:0]      o_st_wstrb,
    output logic [XLEN-1:0] o_ld_data
);

    logic [2:0]      w_lane;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_ld_shifted;

    assign w_lane       = lane_offset(i_funct3, i_off);
    assign w_shamt      = {w_lane, 3'b000};
    assign o_st_wdata   = i_st_data << w_shamt;
    assign w_ld_shifted = i_ld_word >> w_shamt;

    always_comb begin
        o_st_wstrb = 8'h00;
        case (i_funct3)
            F3_SB:   o_st_wstrb = 8'h01 << w_lane;
            F3_SH:   o_st_wstrb = 8'h03 << w_lane;
            F3_SW:   o_st_wstrb = 8'h0F << w_lane;
            F3_SD:   o_st_wstrb = 8'hFF;
            default: o_st_wstrb = 8'h00;
        endcase
    end

    always_comb begin
        o_ld_data = '0;
        case (i_funct3)
            F3_LB:   o_ld_data = {{56{w_ld_shifted[7]}},  w_ld_shifted[7:0]};
            F3_LH:   o_ld_data = {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            F3_LW:   o_ld_data = {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
            F3_LD:   o_ld_data = w_ld_shifted;
            F3_LBU:  o_ld_data = {56'd0, w_ld_shifted[7:0]};
            F3_LHU:  o_ld_data = {48'd0, w_ld_shifted[15:0]};
            F3_LWU:  o_ld_data = {32'd0, w_ld_shifted[31:0]};
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage between EX/MEM and MEM/WB: issues loads/stores over a valid/ready
// channel, stalls upstream while busy. Optional trap build: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    input  logic [63:0]       alu_result,
    input  logic              reg_write,
    input  logic [4:0]        rd_addr,
    output logic              stall_out,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [63:0]       dmem_req_wdata,
    output logic [7:0]        dmem_req_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [63:0]       dmem_rsp_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd_addr,
    output logic [63:0]       wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic              r_reg_write;
    logic [63:0]       r_wdata;
    logic              w_memop;
    logic              w_misaligned;
    logic [63:0]       w_st_wdata;
    logic [7:0]        w_st_wstrb;
    logic [63:0]       w_ld_data;

    assign w_memop = in_valid & (mem_read | mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = !is_aligned(funct3, addr[2:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Request fields come straight from the captured op, so they hold until the handshake.
    mem_lane_align u_align (
        .i_funct3   (r_funct3),
        .i_off      (r_addr[2:0]),
        .i_st_data  (r_wdata),
        .i_ld_word  (dmem_rsp_rdata),
        .o_st_wdata (w_st_wdata),
        .o_st_wstrb (w_st_wstrb),
        .o_ld_data  (w_ld_data)
    );

    assign dmem_req_valid = (r_state == REQ);
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign dmem_req_wdata = w_st_wdata;
    assign dmem_req_wstrb = r_we ? w_st_wstrb : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stall_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    stall_out = 1'b1;
                    w_next    = w_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (dmem_req_ready) w_next = r_we ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                stall_out = 1'b1;
                if (dmem_rsp_valid) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_wdata     <= 64'd0;
        end else if (r_state == IDLE && w_memop) begin
            r_we        <= mem_write;
            r_addr      <= addr;
            r_funct3    <= funct3;
            r_rd        <= rd_addr;
            r_reg_write <= reg_write;
            r_wdata     <= mem_write ? wdata : 64'd0;
        end
    end

    // wb_valid is raised on every transition into DONE, so it pulses exactly once per op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd_addr    <= 5'd0;
            wb_data       <= 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign      <= 1'b0;
            misalign_addr <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop && w_misaligned) begin
                        wb_valid      <= 1'b1;
                        wb_reg_write  <= 1'b0;
                        wb_rd_addr    <= rd_addr;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign      <= 1'b1;
                        misalign_addr <= addr;
`endif
                    end else if (w_memop || !in_valid) begin
                        wb_valid     <= 1'b0;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        wb_reg_write <= reg_write;
                        wb_rd_addr   <= rd_addr;
                    end
                end
                REQ: begin
                    if (dmem_req_ready && r_we) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                        wb_rd_addr   <= r_rd;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= w_ld_data;
                        wb_reg_write <= r_reg_write;
                        wb_rd_addr   <= r_rd;
                    end
                end
                default: begin
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign     <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; also exercises the
// MEM_MISALIGN_TRAP_EN build when that macro is defined.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata, alu_result;
    logic [4:0]  rd_addr;
    logic        stall_out, dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [63:0] dmem_req_addr, dmem_req_wdata;
    logic [7:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
    logic [63:0] misalign_addr;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .alu_result     (alu_result),
        .reg_write      (reg_write),
        .rd_addr        (rd_addr),
        .stall_out      (stall_out),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_wstrb (dmem_req_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign),
        .misalign_addr  (misalign_addr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; funct3 = 3'b000;
        addr = 64'd0; wdata = 64'd0; alu_result = 64'd0; reg_write = 0; rd_addr = 5'd0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 64'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if (dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%0h exp=0", dmem_req_valid); end
        checks++; if (dmem_req_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_we got=%0h exp=0", dmem_req_we); end
        checks++; if ({dmem_req_addr, dmem_req_wdata, dmem_req_wstrb} !== 136'd0) begin failures++; $display("[TB] FAIL reset_req_fields got=%h/%h/%h exp=0", dmem_req_addr, dmem_req_wdata, dmem_req_wstrb); end
        checks++; if ({wb_valid, wb_reg_write} !== 2'b00) begin failures++; $display("[TB] FAIL reset_wb_flags got=%b exp=00", {wb_valid, wb_reg_write}); end
        checks++; if ({wb_rd_addr, wb_data} !== 69'd0) begin failures++; $display("[TB] FAIL reset_wb_data got=%h/%h exp=0", wb_rd_addr, wb_data); end
        checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0h exp=0", stall_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu(input logic [63:0] res, input logic [4:0] rd, input logic rw);
        in_valid = 1; alu_result = res; rd_addr = rd; reg_write = rw;
        #1;
        checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL alu_stall got=%0h exp=0", stall_out); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("[TB] FAIL alu_wb_valid got=%0h exp=1", wb_valid); end
        checks++; if (wb_data !== res) begin failures++; $display("[TB] FAIL alu_wb_data got=%h exp=%h", wb_data, res); end
        checks++; if (wb_rd_addr !== rd) begin failures++; $display("[TB] FAIL alu_wb_rd got=%0d exp=%0d", wb_rd_addr, rd); end
        checks++; if (wb_reg_write !== rw) begin failures++; $display("[TB] FAIL alu_wb_reg_write got=%0h exp=%0h", wb_reg_write, rw); end
        checks++; if (stall_out !== 1'b0 || dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL alu_no_stall got=%0h/%0h exp=0/0", stall_out, dmem_req_valid); end
        idle_inputs();
        tick();
        checks++; if ({wb_valid, wb_reg_write} !== 2'b00) begin failures++; $display("[TB] FAIL alu_idle_wb got=%b exp=00", {wb_valid, wb_reg_write}); end
    endtask

    task automatic test_store(input string nm, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                              input int ready_delay, input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                              input logic [63:0] exp_wdata);
        in_valid = 1; mem_write = 1; funct3 = f3; addr = a; wdata = wd; reg_write = 1; rd_addr = 5'd3;
        dmem_req_ready = 0;
        #1;
        checks++; if (stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_idle_stall got=%0h/%0h exp=1/0", nm, stall_out, dmem_req_valid); end
        tick();
        checks++; if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b1) begin failures++; $display("[TB] FAIL %s_req got=%0h/%0h exp=1/1", nm, dmem_req_valid, dmem_req_we); end
        checks++; if (dmem_req_addr !== exp_addr) begin failures++; $display("[TB] FAIL %s_addr got=%h exp=%h", nm, dmem_req_addr, exp_addr); end
        checks++; if (dmem_req_wstrb !== exp_strb) begin failures++; $display("[TB] FAIL %s_wstrb got=%h exp=%h", nm, dmem_req_wstrb, exp_strb); end
        checks++; if (dmem_req_wdata !== exp_wdata) begin failures++; $display("[TB] FAIL %s_wdata got=%h exp=%h", nm, dmem_req_wdata, exp_wdata); end
        for (int i = 1; i < ready_delay; i++) begin
            tick();
            checks++; if ({dmem_req_valid, stall_out, wb_valid} !== 3'b110 || dmem_req_wstrb !== exp_strb) begin failures++; $display("[TB] FAIL %s_hold got=%b/%h exp=110/%h", nm, {dmem_req_valid, stall_out, wb_valid}, dmem_req_wstrb, exp_strb); end
        end
        dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL %s_done_wb got=%0h/%0h exp=1/0", nm, wb_valid, wb_reg_write); end
        checks++; if (stall_out !== 1'b0 || dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL %s_done_stall got=%0h/%0h exp=0/0", nm, stall_out, dmem_req_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({wb_valid, dmem_req_valid, stall_out} !== 3'b000) begin failures++; $display("[TB] FAIL %s_after got=%b exp=000", nm, {wb_valid, dmem_req_valid, stall_out}); end
    endtask

    task automatic test_load(input string nm, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdata,
                             input int rsp_delay, input logic [63:0] exp_data);
        in_valid = 1; mem_read = 1; funct3 = f3; addr = a; reg_write = 1; rd_addr = 5'd7;
        alu_result = 64'hDEAD; dmem_req_ready = 1;
        #1;
        checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL %s_idle_stall got=%0h exp=1", nm, stall_out); end
        tick();
        checks++; if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b0 || dmem_req_wstrb !== 8'h00) begin failures++; $display("[TB] FAIL %s_req got=%0h/%0h/%h exp=1/0/00", nm, dmem_req_valid, dmem_req_we, dmem_req_wstrb); end
        checks++; if (dmem_req_addr !== {a[63:3], 3'b000}) begin failures++; $display("[TB] FAIL %s_addr got=%h exp=%h", nm, dmem_req_addr, {a[63:3], 3'b000}); end
        tick();
        dmem_req_ready = 0;
        checks++; if ({wb_valid, stall_out, dmem_req_valid} !== 3'b010) begin failures++; $display("[TB] FAIL %s_wait got=%b exp=010", nm, {wb_valid, stall_out, dmem_req_valid}); end
        for (int i = 0; i < rsp_delay; i++) begin
            tick();
            checks++; if ({wb_valid, stall_out} !== 2'b01) begin failures++; $display("[TB] FAIL %s_wait_hold got=%b exp=01", nm, {wb_valid, stall_out}); end
        end
        dmem_rsp_valid = 1; dmem_rsp_rdata = rdata;
        tick();
        dmem_rsp_valid = 0; dmem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++; if (wb_valid !== 1'b1 || stall_out !== 1'b0) begin failures++; $display("[TB] FAIL %s_done got=%0h/%0h exp=1/0", nm, wb_valid, stall_out); end
        checks++; if (wb_data !== exp_data) begin failures++; $display("[TB] FAIL %s_data got=%h exp=%h", nm, wb_data, exp_data); end
        checks++; if (wb_reg_write !== 1'b1 || wb_rd_addr !== 5'd7) begin failures++; $display("[TB] FAIL %s_rd got=%0h/%0d exp=1/7", nm, wb_reg_write, wb_rd_addr); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({wb_valid, dmem_req_valid} !== 2'b00) begin failures++; $display("[TB] FAIL %s_pulse got=%b exp=00", nm, {wb_valid, dmem_req_valid}); end
    endtask

    task automatic test_stray_handshakes();
        dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h1111_2222_3333_4444; dmem_req_ready = 1;
        tick(); tick();
        checks++; if ({wb_valid, dmem_req_valid, stall_out} !== 3'b000) begin failures++; $display("[TB] FAIL stray_ignored got=%b exp=000", {wb_valid, dmem_req_valid, stall_out}); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        in_valid = 1; mem_read = 1; funct3 = 3'b011; addr = 64'h4000; reg_write = 1; rd_addr = 5'd9;
        dmem_req_ready = 1;
        tick();
        tick();
        dmem_req_ready = 0;
        checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_waiting got=%0h exp=1", stall_out); end
        rst = 1; idle_inputs();
        #1;
        checks++; if ({dmem_req_valid, wb_valid, stall_out} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_async got=%b exp=000", {dmem_req_valid, wb_valid, stall_out}); end
        tick();
        rst = 0;
        dmem_rsp_valid = 1; dmem_rsp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        tick(); tick();
        checks++; if (wb_valid !== 1'b0 || wb_data !== 64'd0) begin failures++; $display("[TB] FAIL rstmid_late_rsp got=%0h/%h exp=0/0", wb_valid, wb_data); end
        checks++; if (dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_req got=%0h exp=0", dmem_req_valid); end
        idle_inputs();
        tick();
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        in_valid = 1; mem_read = 1; funct3 = 3'b001; addr = 64'h3001; reg_write = 1; rd_addr = 5'd4;
        dmem_req_ready = 1;
        #1;
        checks++; if (stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mis_idle got=%0h/%0h exp=1/0", stall_out, dmem_req_valid); end
        tick();
        checks++; if (dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mis_no_req got=%0h exp=0", dmem_req_valid); end
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL mis_wb got=%0h/%0h exp=1/0", wb_valid, wb_reg_write); end
        checks++; if (misalign !== 1'b1 || misalign_addr !== 64'h3001) begin failures++; $display("[TB] FAIL mis_flag got=%0h/%h exp=1/3001", misalign, misalign_addr); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({misalign, wb_valid, dmem_req_valid} !== 3'b000) begin failures++; $display("[TB] FAIL mis_pulse got=%b exp=000", {misalign, wb_valid, dmem_req_valid}); end
    endtask
`else
    task automatic test_misalign();
        test_store("sh_mis", 3'b001, 64'h1007, 64'hBEEF, 1, 64'h1000, 8'hC0, 64'hBEEF_0000_0000_0000);
    endtask
`endif

    task automatic test_back_to_back();
        test_store("sd_b2b", 3'b011, 64'h1008, 64'h0102_0304_0506_0708, 1, 64'h1008, 8'hFF, 64'h0102_0304_0506_0708);
        test_alu(64'hCAFE_F00D, 5'd9, 1'b0);
        test_load("lhu_b2b", 3'b101, 64'h2002, 64'h0000_0000_8001_0000, 0, 64'h0000_0000_0000_8001);
        test_alu(64'h55, 5'd31, 1'b1);
    endtask

    initial begin
        test_reset();
        test_alu(64'h1234, 5'd5, 1'b1);
        test_store("sb", 3'b000, 64'h1003, 64'hAB, 2, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000);
        test_store("sh", 3'b001, 64'h1006, 64'hBEEF, 1, 64'h1000, 8'hC0, 64'hBEEF_0000_0000_0000);
        test_store("sw", 3'b010, 64'h1004, 64'hDEAD_BEEF, 1, 64'h1000, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        test_load("lb", 3'b000, 64'h2005, 64'h0000_8000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lbu", 3'b100, 64'h2005, 64'h0000_8000_0000_0000, 0, 64'h0000_0000_0000_0080);
        test_load("lw", 3'b010, 64'h2004, 64'h8765_4321_0000_0000, 3, 64'hFFFF_FFFF_8765_4321);
        test_load("lwu", 3'b110, 64'h2004, 64'h8765_4321_0000_0000, 1, 64'h0000_0000_8765_4321);
        test_load("lh", 3'b001, 64'h2006, 64'h7FFE_0000_0000_0000, 0, 64'h0000_0000_0000_7FFE);
        test_load("ld", 3'b011, 64'h2008, 64'hF0E1_D2C3_B4A5_9687, 0, 64'hF0E1_D2C3_B4A5_9687);
        test_load("f3_111", 3'b111, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        test_stray_handshakes();
        test_misalign();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
